// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave transfer controller, MSB first.
// Synchronises SCLK/CS_N/MOSI into clk, detects their edges and sequences
// per-bit shifting and per-word framing towards a valid/ready word interface.
module spi_slave_ctrl #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_active,
  output logic              tx_underrun
);

  localparam int unsigned BW = $clog2(DATA_W);
  localparam int unsigned FW = $clog2(SYNC_STAGES + 1) + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic [FW-1:0]          flush_q;
  logic                   cs_armed_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t            state_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic              load_pending_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              tx_ready_q;
  logic              tx_underrun_q;
  logic              miso_oe_q;
  logic              frame_active_q;

  logic [DATA_W-1:0] load_word;

  // Pin synchronisers and edge history, preset to idle pin levels.
  // A CS_N fall is only honoured once the chain has flushed and CS_N has been
  // seen high, so a pin held low through reset cannot start a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      flush_q     <= '0;
      cs_armed_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      if (flush_q != FW'(SYNC_STAGES)) begin
        flush_q <= flush_q + 1'b1;
      end else if (cs_s) begin
        cs_armed_q <= 1'b1;
      end
    end
  end

  // Edge strobes from the last synchronised sample versus its history.
  always_comb begin
    sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    cs_s      = cs_sync_q[SYNC_STAGES-1];
    mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_prev_q;
    sclk_fall = ~sclk_s & sclk_prev_q;
    cs_rise   = cs_s & ~cs_prev_q;
    cs_fall   = ~cs_s & cs_prev_q & cs_armed_q;
    load_word = tx_valid ? tx_data : '0;
  end

  // Frame/bit sequencer with registered outputs; CS_N rise has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_shift_q     <= '0;
      tx_shift_q     <= '0;
      load_pending_q <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      tx_ready_q     <= 1'b0;
      tx_underrun_q  <= 1'b0;
      miso_oe_q      <= 1'b0;
      frame_active_q <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      if (cs_rise) begin
        state_q        <= IDLE;
        frame_active_q <= 1'b0;
        miso_oe_q      <= 1'b0;
        bit_cnt_q      <= '0;
        load_pending_q <= 1'b0;
        rx_shift_q     <= '0;
        tx_shift_q     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cs_fall) begin
              state_q        <= SHIFT;
              frame_active_q <= 1'b1;
              miso_oe_q      <= 1'b1;
              bit_cnt_q      <= '0;
              load_pending_q <= 1'b0;
              rx_shift_q     <= '0;
              tx_shift_q     <= load_word;
              tx_ready_q     <= tx_valid;
              tx_underrun_q  <= ~tx_valid;
            end
          end
          SHIFT: begin
            if (sclk_rise) begin
              rx_shift_q <= {rx_shift_q[DATA_W-2:0], mosi_s};
              if (bit_cnt_q == BW'(DATA_W - 1)) begin
                rx_data_q      <= {rx_shift_q[DATA_W-2:0], mosi_s};
                rx_valid_q     <= 1'b1;
                bit_cnt_q      <= '0;
                load_pending_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else if (sclk_fall) begin
              if (load_pending_q) begin
                tx_shift_q     <= load_word;
                tx_ready_q     <= tx_valid;
                tx_underrun_q  <= ~tx_valid;
                load_pending_q <= 1'b0;
              end else begin
                tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign miso         = tx_shift_q[DATA_W-1];
  assign miso_oe      = miso_oe_q;
  assign tx_ready     = tx_ready_q;
  assign tx_underrun  = tx_underrun_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign frame_active = frame_active_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench for spi_slave_ctrl: a bit-level SPI master drives the pins,
// a feeder serves planned tx words, and a monitor checks received words.
module tb_spi_slave_ctrl;

  localparam int unsigned H = 8;  // SCLK half-period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, cs_n, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_active;
  logic       tx_underrun;

  spi_slave_ctrl #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_active (frame_active),
    .tx_underrun  (tx_underrun)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned n_ready = 0;
  int unsigned n_under = 0;
  int unsigned n_rx_got = 0;
  bit          oe_seen = 1'b0;

  logic [7:0] rx_exp[$];  // words the master has completed
  logic [7:0] mw[$];      // words the master sends
  logic [7:0] tw[$];      // words the feeder offers, one per load
  int unsigned feed_idx = 0;
  bit          feed_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Feeder: presents the current planned word and advances on each consumption.
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_ready) feed_idx++;
      tx_valid = feed_en && (feed_idx < tw.size());
      tx_data  = tx_valid ? tw[feed_idx] : 8'h00;
    end
  end

  // Monitor: pops the scoreboard on every rx_valid and tallies pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        n_rx_got++;
        if (rx_exp.size() == 0) chk("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
        else chk("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
      end
      if (tx_ready) n_ready++;
      if (tx_underrun) n_under++;
      if (miso_oe) oe_seen = 1'b1;
    end
  end

  // One CS_N frame of nbits; a non-multiple of 8 aborts the last word.
  // Every completed word is followed by a fall that performs a load.
  task automatic run_frame(input int unsigned nbits, input bit use_valid);
    int unsigned loads;
    int unsigned nfull;
    logic [7:0] w;
    logic       expb;
    nfull    = nbits / 8;
    loads    = 1 + nfull;
    n_ready  = 0;
    n_under  = 0;
    n_rx_got = 0;
    feed_idx = 0;
    feed_en  = use_valid;
    wait_cyc(2);
    cs_n = 1'b0;
    for (int unsigned i = 0; i < nbits; i++) begin
      w    = mw[i / 8];
      mosi = w[7 - (i % 8)];
      wait_cyc(H);
      w    = tw[i / 8];
      expb = use_valid ? w[7 - (i % 8)] : 1'b0;
      chk("miso_bit", 32'(miso), 32'(expb));
      if (i == 0) begin
        chk("frame_active_on", 32'(frame_active), 32'd1);
        chk("miso_oe_on", 32'(miso_oe), 32'd1);
      end
      sclk = 1'b1;
      if (i % 8 == 7) rx_exp.push_back(mw[i / 8]);
      wait_cyc(H);
      sclk = 1'b0;
    end
    wait_cyc(H);
    cs_n = 1'b1;
    wait_cyc(3);
    chk("miso_oe_off", 32'(miso_oe), 32'd0);
    wait_cyc(H);
    feed_en = 1'b0;
    chk("frame_active_off", 32'(frame_active), 32'd0);
    chk("miso_idle", 32'(miso), 32'd0);
    chk("tx_ready_count", n_ready, use_valid ? loads : 0);
    chk("underrun_count", n_under, use_valid ? 0 : loads);
    chk("rx_count", n_rx_got, nfull);
    chk("rx_queue_empty", 32'(rx_exp.size()), 32'd0);
    rx_exp.delete();
  endtask

  task automatic fill_random(input int unsigned nbits);
    mw.delete();
    tw.delete();
    for (int unsigned k = 0; k <= nbits / 8; k++) begin
      mw.push_back(8'($urandom));
      tw.push_back(8'($urandom));
    end
  endtask

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_cyc(5);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_underrun", 32'(tx_underrun), 32'd0);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_frame_active", 32'(frame_active), 32'd0);
    rst = 1'b0;
    wait_cyc(10);

    // Single word.
    mw = '{8'h3C};
    tw = '{8'hA5, 8'($urandom)};
    run_frame(8, 1'b1);

    // Back-to-back three words.
    mw = '{8'h01, 8'hFF, 8'h80};
    tw = '{8'h11, 8'h22, 8'h33, 8'($urandom)};
    run_frame(24, 1'b1);

    // Underrun.
    fill_random(8);
    run_frame(8, 1'b0);

    // Abort after 5 bits, then a clean frame.
    fill_random(5);
    run_frame(5, 1'b1);
    mw = '{8'h5A};
    tw = '{8'($urandom), 8'($urandom)};
    run_frame(8, 1'b1);

    // Reset mid-frame with CS_N held low.
    fill_random(8);
    feed_en  = 1'b1;
    feed_idx = 0;
    wait_cyc(2);
    cs_n = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      mosi = 1'(i);
      wait_cyc(H);
      sclk = 1'b1;
      wait_cyc(H);
      sclk = 1'b0;
    end
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(1);
    chk("mid_rst_frame_active", 32'(frame_active), 32'd0);
    chk("mid_rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("mid_rst_miso", 32'(miso), 32'd0);
    chk("mid_rst_rx_data", 32'(rx_data), 32'd0);
    rst      = 1'b0;
    feed_en  = 1'b0;
    n_ready  = 0;
    n_under  = 0;
    n_rx_got = 0;
    oe_seen  = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      wait_cyc(H);
      sclk = 1'b1;
      wait_cyc(H);
      sclk = 1'b0;
    end
    wait_cyc(H);
    chk("post_rst_no_frame", 32'(frame_active), 32'd0);
    chk("post_rst_no_oe", 32'(oe_seen), 32'd0);
    chk("post_rst_no_load", n_ready + n_under, 32'd0);
    chk("post_rst_no_rx", n_rx_got, 32'd0);
    cs_n = 1'b1;
    wait_cyc(2 * H);
    mw = '{8'hC3};
    tw = '{8'h96, 8'($urandom)};
    run_frame(8, 1'b1);

    // Idle SCLK noise with CS_N high.
    n_ready  = 0;
    n_under  = 0;
    n_rx_got = 0;
    oe_seen  = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      mosi = 1'($urandom);
      wait_cyc(H);
      sclk = 1'b1;
      wait_cyc(H);
      sclk = 1'b0;
    end
    wait_cyc(H);
    chk("idle_no_oe", 32'(oe_seen), 32'd0);
    chk("idle_no_load", n_ready + n_under, 32'd0);
    chk("idle_no_rx", n_rx_got, 32'd0);

    // Randomised frames: random length (some aborted) and tx availability.
    for (int r = 0; r < 20; r++) begin
      int unsigned nb;
      nb = $urandom_range(1, 32);
      fill_random(nb);
      run_frame(nb, 1'($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
